// File: rtl/pe_pkg.sv
// Shared definitions for the processing-element MAC: width derivation, saturation
// limits and accumulator arithmetic-mode constants.
package pe_pkg;

  // Widest accumulator the limit helpers can describe.
  localparam int unsigned MaxAccWidth = 128;

  // SAT_EN settings.
  localparam int unsigned SatWrap  = 0;
  localparam int unsigned SatClamp = 1;

  function automatic int unsigned acc_width(input int unsigned data_width);
    return 2 * data_width + 4;
  endfunction

  // Largest two's-complement value of the given width, right-aligned.
  function automatic logic [MaxAccWidth-1:0] sat_smax(input int unsigned width);
    return {MaxAccWidth{1'b1}} >> (MaxAccWidth - width + 1);
  endfunction

  // Most negative two's-complement value; callers truncate to their width.
  function automatic logic [MaxAccWidth-1:0] sat_smin(input int unsigned width);
    return {MaxAccWidth{1'b1}} << (width - 1);
  endfunction

  function automatic logic [MaxAccWidth-1:0] sat_umax(input int unsigned width);
    return {MaxAccWidth{1'b1}} >> (MaxAccWidth - width);
  endfunction

endpackage

// File: rtl/pe_mac_unit_if.sv
// Operand, forwarding and result signals of one systolic PE. The slave side is the
// PE itself; the master side is whatever feeds and observes it.
interface pe_mac_unit_if
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH)
);

  logic [DATA_WIDTH-1:0] up_i;
  logic                  up_valid_i;
  logic [DATA_WIDTH-1:0] left_i;
  logic                  left_valid_i;
  logic                  signed_i;
  logic                  clear_i;

  logic [DATA_WIDTH-1:0] down_o;
  logic                  down_valid_o;
  logic [DATA_WIDTH-1:0] right_o;
  logic                  right_valid_o;
  logic [ACC_WIDTH-1:0]  res_o;
  logic                  res_valid_o;
  logic                  ovf_o;

  modport slave (
    input  up_i, up_valid_i, left_i, left_valid_i, signed_i, clear_i,
    output down_o, down_valid_o, right_o, right_valid_o, res_o, res_valid_o, ovf_o
  );

  modport master (
    output up_i, up_valid_i, left_i, left_valid_i, signed_i, clear_i,
    input  down_o, down_valid_o, right_o, right_valid_o, res_o, res_valid_o, ovf_o
  );

endinterface

// File: rtl/pe_mul_stage.sv
// Stage 1 of the MAC: registered signed/unsigned multiply, extended to the
// accumulator width, with its valid bit and the operand mode it was taken in.
module pe_mul_stage
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fire_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0]  prod_o,
  output logic                  prod_valid_o,
  output logic                  prod_signed_o
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

  logic signed [ProdWidth-1:0] prod_s;
  logic        [ProdWidth-1:0] prod_u;
  logic        [ACC_WIDTH-1:0] prod_ext;

  logic [ACC_WIDTH-1:0] prod_q;
  logic                 prod_valid_q;
  logic                 prod_signed_q;

  always_comb begin
    prod_s   = ProdWidth'($signed(a_i)) * ProdWidth'($signed(b_i));
    prod_u   = ProdWidth'(a_i) * ProdWidth'(b_i);
    // The signed cast sign-extends; the unsigned one zero-extends.
    prod_ext = signed_i ? ACC_WIDTH'(prod_s) : ACC_WIDTH'(prod_u);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prod_q        <= '0;
      prod_valid_q  <= 1'b0;
      prod_signed_q <= 1'b0;
    end else begin
      prod_valid_q <= fire_i;
      if (fire_i) begin
        prod_q        <= prod_ext;
        prod_signed_q <= signed_i;
      end
    end
  end

  assign prod_o        = prod_q;
  assign prod_valid_o  = prod_valid_q;
  assign prod_signed_o = prod_signed_q;

endmodule

// File: rtl/pe_mac_unit.sv
// Systolic-array processing element: forwards operands east/south and accumulates
// K_LEN products per window into a saturating or wrapping accumulator.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH  = acc_width(DATA_WIDTH),
  parameter int unsigned K_LEN      = 4,
  parameter int unsigned SAT_EN     = SatClamp
) (
  input logic          clk_i,
  input logic          rst_i,
  pe_mac_unit_if.slave bus
);

  localparam int unsigned CntWidth = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(K_LEN - 1);

  if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_bad_acc_width
    $error("pe_mac_unit: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (ACC_WIDTH > MaxAccWidth) begin : g_acc_too_wide
    $error("pe_mac_unit: ACC_WIDTH exceeds MaxAccWidth");
  end
  if (K_LEN < 1) begin : g_bad_k_len
    $error("pe_mac_unit: K_LEN must be at least 1");
  end

  logic fire;

  logic [ACC_WIDTH-1:0] prod;
  logic                 prod_valid;
  logic                 prod_signed;

  logic [DATA_WIDTH-1:0] down_q, right_q;
  logic                  down_valid_q, right_valid_q;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic                 sticky_q, sticky_d;
  logic [ACC_WIDTH-1:0] res_q, res_d;
  logic                 res_valid_q, res_valid_d;
  logic                 ovf_q, ovf_d;

  logic [ACC_WIDTH:0]   sum_ext;
  logic [ACC_WIDTH-1:0] sum;
  logic [ACC_WIDTH-1:0] limit;
  logic [ACC_WIDTH-1:0] acc_add;
  logic                 add_ovf;
  logic                 window_end;

  assign fire = bus.up_valid_i & bus.left_valid_i & ~bus.clear_i;

  pe_mul_stage #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mul (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .fire_i       (fire),
    .signed_i     (bus.signed_i),
    .a_i          (bus.up_i),
    .b_i          (bus.left_i),
    .prod_o       (prod),
    .prod_valid_o (prod_valid),
    .prod_signed_o(prod_signed)
  );

  // Accumulate datapath: overflow is judged in the mode the product was taken in.
  always_comb begin
    sum_ext = {1'b0, acc_q} + {1'b0, prod};
    sum     = sum_ext[ACC_WIDTH-1:0];

    if (prod_signed) begin
      add_ovf = (acc_q[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) &&
                (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      add_ovf = sum_ext[ACC_WIDTH];
    end

    if (!prod_signed) begin
      limit = ACC_WIDTH'(sat_umax(ACC_WIDTH));
    end else if (acc_q[ACC_WIDTH-1]) begin
      limit = ACC_WIDTH'(sat_smin(ACC_WIDTH));
    end else begin
      limit = ACC_WIDTH'(sat_smax(ACC_WIDTH));
    end

    acc_add = sum;
    if (SAT_EN == SatClamp) begin
      // Once clamped, the accumulator is pinned until the window closes.
      if (sticky_q) begin
        acc_add = acc_q;
      end else if (add_ovf) begin
        acc_add = limit;
      end
    end
  end

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    res_d       = res_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    window_end  = prod_valid && (cnt_q == CntLast);

    if (bus.clear_i) begin
      acc_d    = '0;
      cnt_d    = '0;
      sticky_d = 1'b0;
    end else if (prod_valid) begin
      if (window_end) begin
        res_d       = acc_add;
        res_valid_d = 1'b1;
        ovf_d       = sticky_q | add_ovf;
        acc_d       = '0;
        cnt_d       = '0;
        sticky_d    = 1'b0;
      end else begin
        acc_d    = acc_add;
        cnt_d    = cnt_q + 1'b1;
        sticky_d = sticky_q | add_ovf;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      down_q        <= '0;
      down_valid_q  <= 1'b0;
      right_q       <= '0;
      right_valid_q <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      sticky_q      <= 1'b0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      ovf_q         <= 1'b0;
    end else begin
      down_q        <= bus.up_i;
      down_valid_q  <= bus.up_valid_i;
      right_q       <= bus.left_i;
      right_valid_q <= bus.left_valid_i;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      sticky_q      <= sticky_d;
      res_q         <= res_d;
      res_valid_q   <= res_valid_d;
      ovf_q         <= ovf_d;
    end
  end

  assign bus.down_o        = down_q;
  assign bus.down_valid_o  = down_valid_q;
  assign bus.right_o       = right_q;
  assign bus.right_valid_o = right_valid_q;
  assign bus.res_o         = res_q;
  assign bus.res_valid_o   = res_valid_q;
  assign bus.ovf_o         = ovf_q;

endmodule

// File: tb/tb_pe_mac_unit.sv
// Directed bench for pe_mac_unit: three instances (24-bit saturating, 16-bit
// saturating, 16-bit wrapping) share one operand stream.
module tb_pe_mac_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] up, left;
  logic       up_v, left_v, sgn, clr;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_mac_unit_if #(.DATA_WIDTH(8), .ACC_WIDTH(24)) if_a ();
  pe_mac_unit_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if_b ();
  pe_mac_unit_if #(.DATA_WIDTH(8), .ACC_WIDTH(16)) if_c ();

  assign if_a.up_i = up;   assign if_a.up_valid_i = up_v;   assign if_a.left_i = left;
  assign if_a.left_valid_i = left_v; assign if_a.signed_i = sgn; assign if_a.clear_i = clr;
  assign if_b.up_i = up;   assign if_b.up_valid_i = up_v;   assign if_b.left_i = left;
  assign if_b.left_valid_i = left_v; assign if_b.signed_i = sgn; assign if_b.clear_i = clr;
  assign if_c.up_i = up;   assign if_c.up_valid_i = up_v;   assign if_c.left_i = left;
  assign if_c.left_valid_i = left_v; assign if_c.signed_i = sgn; assign if_c.clear_i = clr;

  pe_mac_unit #(.DATA_WIDTH(8), .ACC_WIDTH(24), .K_LEN(4), .SAT_EN(1)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(if_a)
  );
  pe_mac_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_LEN(4), .SAT_EN(1)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(if_b)
  );
  pe_mac_unit #(.DATA_WIDTH(8), .ACC_WIDTH(16), .K_LEN(4), .SAT_EN(0)) u_c (
    .clk_i(clk), .rst_i(rst), .bus(if_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [7:0] u, input logic uv, input logic [7:0] l,
                       input logic lv, input logic s, input logic c);
    up = u; up_v = uv; left = l; left_v = lv; sgn = s; clr = c;
    @(posedge clk);
    #1;
  endtask

  // Forwarding model: every output is the input seen at the previous edge.
  logic [7:0] e_down, e_right;
  logic       e_down_v, e_right_v;
  always @(posedge clk) begin
    e_down    = rst ? 8'd0 : up;
    e_down_v  = rst ? 1'b0 : up_v;
    e_right   = rst ? 8'd0 : left;
    e_right_v = rst ? 1'b0 : left_v;
    #1;
    chk("fwd_down", 32'(if_a.down_o), 32'(e_down));
    chk("fwd_down_valid", 32'(if_a.down_valid_o), 32'(e_down_v));
    chk("fwd_right", 32'(if_a.right_o), 32'(e_right));
    chk("fwd_right_valid", 32'(if_a.right_valid_o), 32'(e_right_v));
  end

  // Pairs listed in arrival order: element [3] is the first pair, [0] the last.
  typedef struct packed {
    logic [3:0][7:0] up;
    logic [3:0][7:0] left;
    logic [3:0]      sgn;
    logic [23:0]     res_a;
    logic            ovf_a;
    logic [15:0]     res_b;
    logic            ovf_b;
    logic [15:0]     res_c;
    logic            ovf_c;
  } vec_t;

  typedef struct packed {
    logic [7:0] u;
    logic       uv;
    logic [7:0] l;
    logic       lv;
    logic       exp_rv;
  } step_t;

  localparam int NumVec  = 6;
  localparam int NumStep = 10;

  vec_t  vecs[NumVec];
  step_t steps[NumStep];
  vec_t  v;
  int    pulses;
  logic [23:0] last_res;

  initial begin
    vecs[0] = '{up: {8'd1, 8'd3, 8'd5, 8'd7}, left: {8'd2, 8'd4, 8'd6, 8'd8}, sgn: 4'b0000,
                res_a: 24'd100, ovf_a: 1'b0, res_b: 16'd100, ovf_b: 1'b0,
                res_c: 16'd100, ovf_c: 1'b0};
    vecs[1] = '{up: {8'(-3), 8'd4, 8'(-1), 8'd2}, left: {8'd5, 8'(-2), 8'(-1), 8'd2},
                sgn: 4'b1111, res_a: 24'hFFFFEE, ovf_a: 1'b0, res_b: 16'hFFEE, ovf_b: 1'b0,
                res_c: 16'hFFEE, ovf_c: 1'b0};
    vecs[2] = '{up: {4{8'd255}}, left: {4{8'd255}}, sgn: 4'b0000,
                res_a: 24'd260100, ovf_a: 1'b0, res_b: 16'hFFFF, ovf_b: 1'b1,
                res_c: 16'((4 * 65025) % 65536), ovf_c: 1'b1};
    vecs[3] = '{up: {4{8'h80}}, left: {4{8'h80}}, sgn: 4'b1111,
                res_a: 24'h010000, ovf_a: 1'b0, res_b: 16'h7FFF, ovf_b: 1'b1,
                res_c: 16'h0000, ovf_c: 1'b1};
    vecs[4] = '{up: {4{8'h80}}, left: {4{8'd127}}, sgn: 4'b1111,
                res_a: 24'hFF0200, ovf_a: 1'b0, res_b: 16'h8000, ovf_b: 1'b1,
                res_c: 16'h0200, ovf_c: 1'b1};
    // Mixed modes: -1 (signed), then 255 (unsigned) carries out of all-ones.
    vecs[5] = '{up: {8'(-1), 8'd255, 8'd2, 8'd0}, left: {8'd1, 8'd1, 8'd3, 8'd9},
                sgn: 4'b1010, res_a: 24'hFFFFFF, ovf_a: 1'b1, res_b: 16'hFFFF, ovf_b: 1'b1,
                res_c: 16'd260, ovf_c: 1'b1};

    steps[0] = '{u: 8'd1,  uv: 1'b1, l: 8'd2,    lv: 1'b1, exp_rv: 1'b0};
    steps[1] = '{u: 8'd0,  uv: 1'b0, l: 8'd0,    lv: 1'b0, exp_rv: 1'b0};
    steps[2] = '{u: 8'hAA, uv: 1'b1, l: 8'd0,    lv: 1'b0, exp_rv: 1'b0};
    steps[3] = '{u: 8'd3,  uv: 1'b1, l: 8'd4,    lv: 1'b1, exp_rv: 1'b0};
    steps[4] = '{u: 8'd0,  uv: 1'b0, l: 8'h33,   lv: 1'b1, exp_rv: 1'b0};
    steps[5] = '{u: 8'd0,  uv: 1'b0, l: 8'd0,    lv: 1'b0, exp_rv: 1'b0};
    steps[6] = '{u: 8'd5,  uv: 1'b1, l: 8'd6,    lv: 1'b1, exp_rv: 1'b0};
    steps[7] = '{u: 8'd7,  uv: 1'b1, l: 8'd8,    lv: 1'b1, exp_rv: 1'b0};
    steps[8] = '{u: 8'h11, uv: 1'b0, l: 8'h22,   lv: 1'b0, exp_rv: 1'b1};
    steps[9] = '{u: 8'd0,  uv: 1'b0, l: 8'd0,    lv: 1'b0, exp_rv: 1'b0};

    rst = 1'b1;
    up = '0; left = '0; up_v = 1'b0; left_v = 1'b0; sgn = 1'b0; clr = 1'b0;
    drive(8'h12, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0);
    drive(8'h12, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0);
    chk("reset_res", 32'(if_a.res_o), 32'd0);
    chk("reset_res_valid", 32'(if_a.res_valid_o), 32'd0);
    chk("reset_ovf", 32'(if_a.ovf_o), 32'd0);
    rst = 1'b0;

    // Table of full windows, each followed by two idle cycles.
    for (int i = 0; i < NumVec; i++) begin
      v = vecs[i];
      for (int k = 0; k < 4; k++) begin
        drive(v.up[3-k], 1'b1, v.left[3-k], 1'b1, v.sgn[3-k], 1'b0);
      end
      chk($sformatf("v%0d_early_valid", i), 32'(if_a.res_valid_o), 32'd0);
      drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_valid_a", i), 32'(if_a.res_valid_o), 32'd1);
      chk($sformatf("v%0d_valid_c", i), 32'(if_c.res_valid_o), 32'd1);
      chk($sformatf("v%0d_res_a", i), 32'(if_a.res_o), 32'(v.res_a));
      chk($sformatf("v%0d_ovf_a", i), 32'(if_a.ovf_o), 32'(v.ovf_a));
      chk($sformatf("v%0d_res_b", i), 32'(if_b.res_o), 32'(v.res_b));
      chk($sformatf("v%0d_ovf_b", i), 32'(if_b.ovf_o), 32'(v.ovf_b));
      chk($sformatf("v%0d_res_c", i), 32'(if_c.res_o), 32'(v.res_c));
      chk($sformatf("v%0d_ovf_c", i), 32'(if_c.ovf_o), 32'(v.ovf_c));
      drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("v%0d_pulse_end", i), 32'(if_a.res_valid_o), 32'd0);
      chk($sformatf("v%0d_res_hold", i), 32'(if_a.res_o), 32'(v.res_a));
    end

    // Gaps and single-valid cycles must not disturb the window.
    for (int i = 0; i < NumStep; i++) begin
      drive(steps[i].u, steps[i].uv, steps[i].l, steps[i].lv, 1'b0, 1'b0);
      chk($sformatf("gap%0d_valid", i), 32'(if_a.res_valid_o), 32'(steps[i].exp_rv));
      if (steps[i].exp_rv) chk("gap_res", 32'(if_a.res_o), 32'd100);
    end

    // Clear after two pairs, with a colliding fire that must be dropped.
    pulses = 0;
    last_res = '0;
    for (int i = 0; i < 11; i++) begin
      if (i < 2)      drive(8'd5, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
      else if (i == 2) drive(8'd5, 1'b1, 8'd5, 1'b1, 1'b0, 1'b1);
      else if (i < 7) drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
      else            drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (if_a.res_valid_o) begin
        pulses++;
        last_res = if_a.res_o;
      end
    end
    chk("clear_pulses", 32'(pulses), 32'd1);
    chk("clear_res", 32'(last_res), 32'd4);
    chk("clear_ovf_held", 32'(if_a.ovf_o), 32'd0);

    // Reset mid-window discards the partial sum.
    drive(8'd9, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    drive(8'd9, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    drive(8'h5A, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    chk("rst_mid_res", 32'(if_a.res_o), 32'd0);
    chk("rst_mid_res_valid", 32'(if_a.res_valid_o), 32'd0);
    chk("rst_mid_ovf", 32'(if_a.ovf_o), 32'd0);
    chk("rst_mid_down", 32'(if_a.down_o), 32'd0);
    for (int i = 0; i < 12; i++) begin
      if (i < 8) drive(8'd1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0);
      else       drive(8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("rst_seq%0d_valid", i), 32'(if_a.res_valid_o), 32'(i == 4 || i == 8));
      if (i == 4 || i == 8) chk($sformatf("rst_seq%0d_res", i), 32'(if_a.res_o), 32'd4);
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
